mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 tb/tb_mul_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit, one iteration per clock, RF write port.
// Define MULDIV_EARLY_EXIT_EN to finish trivial/special operands in one cycle.
module mul_div_unit #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  kill,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   input  logic [REG_ADDR_W-1:0] dest,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] write_reg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state;
   logic [1:0]           op_q;
   logic                 sa_q;
   logic                 sb_q;
   logic                 bz_q;
   logic [WIDTH-1:0]     opnd_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_nx;
   logic [WIDTH:0]       div_top;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_nx;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     fin;
   logic                 early;
   logic [WIDTH-1:0]     early_res;

   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;

   // Multiply: acc = {partial, multiplier}, add then shift right
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}, shift left then trial subtract
   assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff = div_top - {1'b0, opnd_q};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_nx   = {div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ge};

   assign acc_nx = op_q[1] ? div_nx : mul_nx;
   assign prod_s = (sa_q ^ sb_q) ? -mul_nx : mul_nx;
   assign quo    = div_nx[WIDTH-1:0];
   assign rem    = div_nx[2*WIDTH-1:WIDTH];

   always_comb begin
      fin = '0;
      unique case (op_q)
         2'b00: fin = prod_s[WIDTH-1:0];
         2'b01: fin = prod_s[2*WIDTH-1:WIDTH];
         2'b10: fin = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
         2'b11: fin = sa_q ? -rem : rem;
      endcase
   end

   always_comb begin
      early     = 1'b0;
      early_res = '0;
`ifdef MULDIV_EARLY_EXIT_EN
      if (op[1]) begin
         if (b == '0) begin
            early     = 1'b1;
            early_res = op[0] ? a : '1;
         end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
            early     = 1'b1;
            early_res = op[0] ? '0 : a;
         end
      end else begin
         early = (a == '0) || (b == '0);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         bz_q      <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result    <= '0;
         write_reg <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start && !kill) begin
                  op_q      <= op;
                  write_reg <= dest;
                  sa_q      <= a[WIDTH-1];
                  sb_q      <= b[WIDTH-1];
                  bz_q      <= (b == '0);
                  opnd_q    <= b_mag;
                  acc_q     <= {{WIDTH{1'b0}}, a_mag};
                  cnt_q     <= '0;
                  if (early) begin
                     result <= early_res;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (kill) begin
                  state <= S_IDLE;
               end else begin
                  acc_q <= acc_nx;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(WIDTH-1)) begin
                     result <= fin;
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE) && !kill;
   assign reg_write = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, reset/kill/busy handling.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        kill;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  dest;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        reg_write;
   logic [4:0]  write_reg;

   int passed = 0;
   int total  = 0;

`ifdef MULDIV_EARLY_EXIT_EN
   localparam int EL = 1;
`else
   localparam int EL = 33;
`endif

   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
      .a(a), .b(b), .dest(dest), .busy(busy), .done(done),
      .result(result), .reg_write(reg_write), .write_reg(write_reg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] d, input logic [31:0] exp,
                         input int lat);
      int cyc;
      bit seen;
      op = o; a = x; b = y; dest = d; start = 1'b1;
      tick();
      start = 1'b0; a = $urandom; b = $urandom; dest = d + 5'd1;
      cyc = 1; seen = 1'b0;
      while (cyc < 40 && !seen) begin
         if (done) seen = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      chk({tag, " done"}, 32'(seen), 32'd1);
      chk({tag, " lat"}, 32'(cyc), 32'(lat));
      chk({tag, " res"}, result, exp);
      chk({tag, " rw"}, 32'(reg_write), 32'd1);
      chk({tag, " wreg"}, 32'(write_reg), 32'(d));
      tick();
      chk({tag, " done1"}, 32'(done), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int nd;
      int dc;
      logic [31:0] dr;
      logic [4:0]  dw;
      rst = 1'b1; start = 1'b0; kill = 1'b0;
      op = 2'b00; a = '0; b = '0; dest = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst rw", 32'(reg_write), 32'd0);
      chk("rst res", result, 32'd0);
      chk("rst wreg", 32'(write_reg), 32'd0);

      // reset in the middle of RUN
      op = 2'b00; a = 32'd7; b = 32'd6; dest = 5'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      chk("midrst busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst idle", 32'(busy), 32'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || reg_write) nd++;
         tick();
      end
      chk("midrst nodone", 32'(nd), 32'd0);
      chk("midrst res", result, 32'd0);

      // MUL -7*6 with ignored start pulses at cycles 5 and 33
      op = 2'b00; a = -32'sd7; b = 32'd6; dest = 5'd3; start = 1'b1;
      tick();
      nd = 0; dc = 0; dr = '0; dw = '0;
      for (int c = 1; c <= 45; c++) begin
         start = (c == 5 || c == 33);
         op = 2'b10; a = 32'd1; b = 32'd1; dest = 5'd9;
         if (done) begin
            nd++; dc = c; dr = result; dw = write_reg;
         end
         tick();
      end
      start = 1'b0;
      chk("mul ndone", 32'(nd), 32'd1);
      chk("mul cyc", 32'(dc), 32'd33);
      chk("mul res", dr, 32'hFFFF_FFD6);
      chk("mul wreg", 32'(dw), 32'd3);

      run_op("mulh big", 2'b01, 32'h4000_0000, 32'd8, 5'd4, 32'd2, 33);
      run_op("mulh neg", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd5,
             32'hFFFF_FFFF, 33);
      run_op("div -7/2", 2'b10, -32'sd7, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
      run_op("rem -7%2", 2'b11, -32'sd7, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
      run_op("rem 7%-2", 2'b11, 32'd7, -32'sd2, 5'd8, 32'd1, 33);
      run_op("div 5/0", 2'b10, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, EL);
      run_op("rem 5%0", 2'b11, 32'd5, 32'd0, 5'd10, 32'd5, EL);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
             32'h8000_0000, EL);
      run_op("rem ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
             32'd0, EL);
      run_op("mul x0", 2'b00, 32'd123, 32'd0, 5'd13, 32'd0, EL);

      // kill at cycle 20, restart in cycle 21
      op = 2'b10; a = 32'd100; b = 32'd7; dest = 5'd14; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 20; i++) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill idle", 32'(busy), 32'd0);
      run_op("after kill", 2'b00, 32'd7, 32'd6, 5'd15, 32'd42, 33);

      // kill during the DONE cycle gates the write
      op = 2'b11; a = 32'd100; b = 32'd7; dest = 5'd16; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 33; i++) tick();
      chk("kd done", 32'(done), 32'd1);
      chk("kd res", result, 32'd2);
      kill = 1'b1;
      #1;
      chk("kd gate", 32'(done), 32'd0);
      chk("kd rw", 32'(reg_write), 32'd0);
      tick();
      kill = 1'b0;
      chk("kd idle", 32'(busy), 32'd0);

      // kill with start in IDLE: start ignored
      start = 1'b1; kill = 1'b1;
      tick();
      start = 1'b0; kill = 1'b0;
      chk("ks idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
